dcache_controller: RTL



---
 rtl/dcache_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// dcache_controller : direct-mapped write-back/write-allocate data cache
// Rev 1.0
// ============================================================================
module dcache_controller #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 5,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 5;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_MISS        = 3'd1,
    S_WRITEBACK   = 3'd2,
    S_ALLOCATE    = 3'd3,
    S_REFILL_DONE = 3'd4
  } state_t;

  state_t             state_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINE_W-1:0]  line_q [LINES];
  logic               mem_enable_q;
  logic               mem_write_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [LINE_W-1:0]  mem_data_q;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [2:0]         w_word;
  logic [LINE_W-1:0]  w_line;
  logic               w_req;
  logic               w_hit;
  logic               w_wr_hit;
  logic               w_fill;
  logic               unused_addr_lsb;

  assign w_index  = p1_addr_i[INDEX_W+4:5];
  assign w_tag    = p1_addr_i[ADDR_W-1:INDEX_W+5];
  assign w_word   = p1_addr_i[4:2];
  assign w_line   = line_q[w_index];
  assign w_req    = p1_MemRead_i | p1_MemWrite_i;
  assign w_hit    = valid_q[w_index] & (tag_q[w_index] == w_tag);
  // Stores only commit from IDLE, so a store miss writes once, after the refill.
  assign w_wr_hit = p1_MemWrite_i & w_hit & (state_q == S_IDLE);
  assign w_fill   = (state_q == S_ALLOCATE) & mem_ack_i;
  assign unused_addr_lsb = ^p1_addr_i[1:0];

  assign p1_stall_o   = (w_req & ~w_hit) | (state_q != S_IDLE);
  assign p1_data_o    = w_hit ? w_line[{w_word, 5'd0} +: 32] : 32'd0;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      if (w_wr_hit) dirty_q[w_index] <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (w_req & ~w_hit) state_q <= S_MISS;
        end
        S_MISS: begin
          mem_enable_q <= 1'b1;
          if (valid_q[w_index] & dirty_q[w_index]) begin
            state_q     <= S_WRITEBACK;
            mem_write_q <= 1'b1;
            mem_addr_q  <= {tag_q[w_index], w_index, 5'd0};
            mem_data_q  <= w_line;
          end else begin
            state_q     <= S_ALLOCATE;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {w_tag, w_index, 5'd0};
          end
        end
        S_WRITEBACK: begin
          // Enable stays high straight into the refill read.
          if (mem_ack_i) begin
            state_q     <= S_ALLOCATE;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {w_tag, w_index, 5'd0};
          end
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            state_q          <= S_REFILL_DONE;
            mem_enable_q     <= 1'b0;
            valid_q[w_index] <= 1'b1;
            dirty_q[w_index] <= 1'b0;
          end
        end
        S_REFILL_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          mem_enable_q <= 1'b0;
          mem_write_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      line_q[w_index] <= mem_data_i;
      tag_q[w_index]  <= w_tag;
    end else if (w_wr_hit) begin
      line_q[w_index][{w_word, 5'd0} +: 32] <= p1_data_i;
    end
  end

endmodule
`default_nettype wire
